// File: rtl/counter_sequencer.sv
// Schedule controller for an 8-bit counter core: clear, then reps x (burst enabled, pause idle).
// Moore outputs; abort and overflow can end the schedule early.
module counter_sequencer #(
  parameter int unsigned BURST_W = 8,
  parameter int unsigned PAUSE_W = 8,
  parameter int unsigned REP_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic [PAUSE_W-1:0] cfg_pause,
  input  logic [REP_W-1:0]   cfg_reps,
  input  logic               cfg_stop_on_ovf,
  input  logic               cnt_overflow,
  output logic               cnt_enable,
  output logic               cnt_clear,
  output logic               busy,
  output logic               done,
  output logic               ovf_seen,
  output logic [REP_W-1:0]   rep_idx
);

  typedef enum logic [2:0] {StIdle, StClear, StRun, StPause, StDone} state_e;

  state_e             state_q, state_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [PAUSE_W-1:0] pause_q, pause_d;
  logic [REP_W-1:0]   reps_q, reps_d;
  logic               stop_q, stop_d;
  logic [BURST_W-1:0] burst_left_q, burst_left_d;
  logic [PAUSE_W-1:0] pause_left_q, pause_left_d;
  logic [REP_W-1:0]   rep_idx_q, rep_idx_d;
  logic               ovf_seen_q, ovf_seen_d;
  logic               last_rep;

  assign last_rep = (rep_idx_q == reps_q - REP_W'(1));

  always_comb begin
    state_d      = state_q;
    burst_d      = burst_q;
    pause_d      = pause_q;
    reps_d       = reps_q;
    stop_d       = stop_q;
    burst_left_d = burst_left_q;
    pause_left_d = pause_left_q;
    rep_idx_d    = rep_idx_q;
    ovf_seen_d   = ovf_seen_q;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          burst_d    = (cfg_burst == '0) ? BURST_W'(1) : cfg_burst;
          pause_d    = cfg_pause;
          reps_d     = cfg_reps;
          stop_d     = cfg_stop_on_ovf;
          rep_idx_d  = '0;
          ovf_seen_d = 1'b0;
          state_d    = (cfg_reps == '0) ? StDone : StClear;
        end
      end
      StClear: begin
        if (abort) begin
          state_d = StDone;
        end else begin
          if (cnt_overflow) ovf_seen_d = 1'b1;
          burst_left_d = burst_q;
          state_d      = StRun;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StDone;
        end else begin
          if (cnt_overflow) ovf_seen_d = 1'b1;
          if (cnt_overflow && stop_q) begin
            state_d = StDone;
          end else if (burst_left_q == BURST_W'(1)) begin
            if (last_rep) begin
              state_d = StDone;
            end else if (pause_q == '0) begin
              burst_left_d = burst_q;
              rep_idx_d    = rep_idx_q + REP_W'(1);
            end else begin
              pause_left_d = pause_q;
              state_d      = StPause;
            end
          end else begin
            burst_left_d = burst_left_q - BURST_W'(1);
          end
        end
      end
      StPause: begin
        if (abort) begin
          state_d = StDone;
        end else begin
          if (cnt_overflow) ovf_seen_d = 1'b1;
          if (pause_left_q == PAUSE_W'(1)) begin
            burst_left_d = burst_q;
            rep_idx_d    = rep_idx_q + REP_W'(1);
            state_d      = StRun;
          end else begin
            pause_left_d = pause_left_q - PAUSE_W'(1);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      burst_q      <= '0;
      pause_q      <= '0;
      reps_q       <= '0;
      stop_q       <= 1'b0;
      burst_left_q <= '0;
      pause_left_q <= '0;
      rep_idx_q    <= '0;
      ovf_seen_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_q      <= burst_d;
      pause_q      <= pause_d;
      reps_q       <= reps_d;
      stop_q       <= stop_d;
      burst_left_q <= burst_left_d;
      pause_left_q <= pause_left_d;
      rep_idx_q    <= rep_idx_d;
      ovf_seen_q   <= ovf_seen_d;
    end
  end

  assign cnt_enable = (state_q == StRun);
  assign cnt_clear  = (state_q == StClear);
  assign busy       = (state_q == StClear) || (state_q == StRun) || (state_q == StPause);
  assign done       = (state_q == StDone);
  assign ovf_seen   = ovf_seen_q;
  assign rep_idx    = rep_idx_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer: per-cycle vector table plus long overflow runs,
// abort and mid-schedule reset sequences. Includes a small 8-bit counter core model.
module tb_counter_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] cfg_burst = '0;
  logic [7:0] cfg_pause = '0;
  logic [3:0] cfg_reps = '0;
  logic       cfg_stop_on_ovf = 1'b0;
  logic       cnt_overflow;
  logic       cnt_enable, cnt_clear, busy, done, ovf_seen;
  logic [3:0] rep_idx;

  int n_checks = 0;
  int n_err = 0;

  counter_sequencer #(.BURST_W(8), .PAUSE_W(8), .REP_W(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .abort           (abort),
    .cfg_burst       (cfg_burst),
    .cfg_pause       (cfg_pause),
    .cfg_reps        (cfg_reps),
    .cfg_stop_on_ovf (cfg_stop_on_ovf),
    .cnt_overflow    (cnt_overflow),
    .cnt_enable      (cnt_enable),
    .cnt_clear       (cnt_clear),
    .busy            (busy),
    .done            (done),
    .ovf_seen        (ovf_seen),
    .rep_idx         (rep_idx)
  );

  always #5 clk = ~clk;

  // Counter core model: overflow flagged on the enabled cycle that wraps 255 -> 0.
  logic [7:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt_q <= '0;
    else if (cnt_clear)  cnt_q <= '0;
    else if (cnt_enable) cnt_q <= cnt_q + 8'd1;
  end
  assign cnt_overflow = cnt_enable && (cnt_q == 8'hFF);

  typedef struct {
    logic       start, abort;
    logic [7:0] burst, pause;
    logic [3:0] reps;
    logic       en, clr, bsy, dn;
    logic [3:0] rep;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, input logic ab, input logic [7:0] b, input logic [7:0] p,
                     input logic [3:0] r, input logic en, input logic clr, input logic bsy,
                     input logic dn, input logic [3:0] rep);
    vec_t v;
    v.start = st; v.abort = ab; v.burst = b; v.pause = p; v.reps = r;
    v.en = en; v.clr = clr; v.bsy = bsy; v.dn = dn; v.rep = rep;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic en, input logic clr, input logic bsy,
                         input logic dn, input logic [3:0] rep, input logic ovf);
    chk({tag, ".en"}, 32'(cnt_enable), 32'(en));
    chk({tag, ".clr"}, 32'(cnt_clear), 32'(clr));
    chk({tag, ".busy"}, 32'(busy), 32'(bsy));
    chk({tag, ".done"}, 32'(done), 32'(dn));
    chk({tag, ".rep"}, 32'(rep_idx), 32'(rep));
    chk({tag, ".ovf"}, 32'(ovf_seen), 32'(ovf));
  endtask

  // Launch burst=200 pause=0 reps=2 and measure until done (bounded).
  task automatic ovf_run(input string tag, input logic stop, input int exp_en, input int exp_busy,
                         input int exp_runs);
    int en_n, busy_n, runs;
    logic prev, got_done;
    cfg_burst = 8'd200; cfg_pause = 8'd0; cfg_reps = 4'd2; cfg_stop_on_ovf = stop;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, ".ovf_cleared"}, 32'(ovf_seen), 32'd0);
    chk({tag, ".clear"}, 32'(cnt_clear), 32'd1);
    en_n = 0; busy_n = 0; runs = 0; prev = 1'b0; got_done = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (busy) busy_n++;
      if (cnt_enable) begin
        en_n++;
        if (!prev) runs++;
      end
      prev = cnt_enable;
      @(posedge clk); #1;
    end
    chk({tag, ".got_done"}, 32'(got_done), 32'd1);
    chk({tag, ".en_cycles"}, 32'(en_n), 32'(exp_en));
    chk({tag, ".busy_cycles"}, 32'(busy_n), 32'(exp_busy));
    chk({tag, ".en_runs"}, 32'(runs), 32'(exp_runs));
    chk({tag, ".ovf_seen"}, 32'(ovf_seen), 32'd1);
    chk({tag, ".rep_idx"}, 32'(rep_idx), 32'd1);
    @(posedge clk); #1;
    chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
    chk({tag, ".ovf_sticky"}, 32'(ovf_seen), 32'd1);
  endtask

  initial begin
    // Scenario 1, with a start while busy that must be ignored
    add(1, 0, 3, 2, 2,  0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0,  1, 0, 1, 0, 0);
    add(1, 0, 9, 9, 5,  1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0,  1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0,  0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0,  0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0,  1, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0,  1, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0,  1, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0,  0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0,  0, 0, 0, 0, 1);
    // reps=0: straight to done
    add(1, 0, 3, 2, 0,  0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    // start with abort in idle: no launch
    add(1, 1, 3, 2, 2,  0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    // abort on the 2nd RUN cycle
    add(1, 0, 3, 2, 2,  0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0,  1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0,  1, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0,  0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    // burst=0 latched as 1, pause=0: back-to-back single-cycle bursts
    add(1, 0, 0, 0, 2,  0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0,  1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0,  1, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0,  0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0,  0, 0, 0, 0, 1);

    // Reset state
    #12;
    chk_all("reset", 0, 0, 0, 0, 4'd0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_all("post_reset", 0, 0, 0, 0, 4'd0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].start; abort = vecs[i].abort;
      cfg_burst = vecs[i].burst; cfg_pause = vecs[i].pause; cfg_reps = vecs[i].reps;
      cfg_stop_on_ovf = 1'b0;
      @(posedge clk); #1;
      chk_all($sformatf("v%0d", i), vecs[i].en, vecs[i].clr, vecs[i].bsy, vecs[i].dn,
              vecs[i].rep, 1'b0);
    end
    start = 1'b0; abort = 1'b0;

    // Overflow with stop: 256 contiguous enables, busy = clear + 256
    ovf_run("ovf_stop", 1'b1, 256, 257, 1);
    // Overflow without stop: full schedule runs
    ovf_run("ovf_nostop", 1'b0, 400, 401, 1);

    // Reset during PAUSE
    cfg_burst = 8'd3; cfg_pause = 8'd2; cfg_reps = 4'd2; cfg_stop_on_ovf = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk_all("in_pause", 0, 0, 1, 0, 4'd0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_all("rst_pause", 0, 0, 0, 0, 4'd0, 0);
    @(posedge clk); #1;
    chk_all("rst_hold", 0, 0, 0, 0, 4'd0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_all("rst_idle", 0, 0, 0, 0, 4'd0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
